// File: rtl/stack_call_sequencer_pkg.sv
// Shared opcodes, sequencer states and reset defaults for the stack/call sequencer.
package stack_call_sequencer_pkg;

    localparam int unsigned      DATA_W_DEFAULT   = 16;
    localparam int unsigned      PC_W_DEFAULT     = 32;
    localparam logic [15:0]      SP_RESET_DEFAULT = 16'h03FF;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_A  = 3'd1,
        WR_B  = 3'd2,
        RD_A  = 3'd3,
        RD_B  = 3'd4,
        CAP_A = 3'd5,
        CAP_B = 3'd6
    } state_t;

    function automatic logic is_stack_op(input logic [2:0] op);
        return (op == OP_PUSH) || (op == OP_POP) || (op == OP_CALL) || (op == OP_RET);
    endfunction

endpackage

// File: rtl/stack_call_sequencer_sp.sv
// Stack pointer register: synchronous active-low reset, load/inc/dec, exposes SP and SP+1.
module stack_pointer_reg
    import stack_call_sequencer_pkg::*;
#(
    parameter int unsigned       DATA_W   = DATA_W_DEFAULT,
    parameter logic [DATA_W-1:0] SP_RESET = SP_RESET_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_inc,
    input  logic              i_dec,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_value,
    output logic [DATA_W-1:0] o_sp,
    output logic [DATA_W-1:0] o_sp_plus1
);

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] sp;

    // Arithmetic is modulo 2^DATA_W; wrap-around is intentionally silent.
    always_ff @(posedge i_clk) begin
        if (!i_reset)
            sp <= SP_RESET;
        else if (i_load)
            sp <= i_load_value;
        else if (i_inc)
            sp <= sp + ONE;
        else if (i_dec)
            sp <= sp - ONE;
    end

    assign o_sp       = sp;
    assign o_sp_plus1 = sp + ONE;

endmodule

// File: rtl/stack_call_sequencer.sv
// Sequences the single data-memory port for PUSH/POP/CALL/RET and owns the stack pointer.
module stack_call_sequencer
    import stack_call_sequencer_pkg::*;
#(
    parameter int unsigned       DATA_W   = DATA_W_DEFAULT,
    parameter int unsigned       PC_W     = PC_W_DEFAULT,
    parameter logic [DATA_W-1:0] SP_RESET = SP_RESET_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_op_valid,
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [PC_W-1:0]   i_target,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic              o_stall,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_pop_data,
    output logic              o_pc_load,
    output logic [PC_W-1:0]   o_pc_value,
    output logic [DATA_W-1:0] o_sp
);

    state_t            state;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] push_data_q;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   target_q;
    logic [DATA_W-1:0] low_q;
    logic [DATA_W-1:0] pop_q;

    logic              accept;
    logic              sp_inc;
    logic              sp_dec;
    logic [DATA_W-1:0] sp;
    logic [DATA_W-1:0] sp_plus1;

    assign accept = (state == IDLE) && i_op_valid && is_stack_op(i_op);

    stack_pointer_reg #(
        .DATA_W   (DATA_W),
        .SP_RESET (SP_RESET)
    ) u_sp (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_inc        (sp_inc),
        .i_dec        (sp_dec),
        .i_load       (1'b0),
        .i_load_value ('0),
        .o_sp         (sp),
        .o_sp_plus1   (sp_plus1)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state       <= IDLE;
            op_q        <= OP_NOP;
            push_data_q <= '0;
            pc_q        <= '0;
            target_q    <= '0;
            low_q       <= '0;
            pop_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q        <= i_op;
                        push_data_q <= i_push_data;
                        pc_q        <= i_pc;
                        target_q    <= i_target;
                        state       <= ((i_op == OP_PUSH) || (i_op == OP_CALL)) ? WR_A : RD_A;
                    end
                end
                WR_A:  state <= (op_q == OP_CALL) ? WR_B : IDLE;
                WR_B:  state <= IDLE;
                RD_A:  state <= (op_q == OP_RET) ? RD_B : CAP_A;
                RD_B: begin
                    low_q <= i_mem_rdata;
                    state <= CAP_B;
                end
                CAP_A: begin
                    pop_q <= i_mem_rdata;
                    state <= IDLE;
                end
                CAP_B:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Port drives depend only on registered state, latched operands and SP; the
    // read-data path is the one exception, forwarding the returning word in the capture cycle.
    always_comb begin
        sp_inc      = 1'b0;
        sp_dec      = 1'b0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        o_mem_addr  = sp;
        o_mem_wdata = '0;
        o_done      = 1'b0;
        o_pc_load   = 1'b0;
        o_pc_value  = '0;
        o_pop_data  = pop_q;
        case (state)
            WR_A: begin
                o_mem_write = 1'b1;
                sp_dec      = 1'b1;
                o_mem_wdata = (op_q == OP_CALL) ? pc_q[PC_W-1:DATA_W] : push_data_q;
                o_done      = (op_q == OP_PUSH);
            end
            WR_B: begin
                o_mem_write = 1'b1;
                sp_dec      = 1'b1;
                o_mem_wdata = pc_q[DATA_W-1:0];
                o_pc_load   = 1'b1;
                o_pc_value  = target_q;
                o_done      = 1'b1;
            end
            RD_A, RD_B: begin
                o_mem_read = 1'b1;
                o_mem_addr = sp_plus1;
                sp_inc     = 1'b1;
            end
            CAP_A: begin
                o_pop_data = i_mem_rdata;
                o_done     = 1'b1;
            end
            CAP_B: begin
                o_pc_load  = 1'b1;
                o_pc_value = {i_mem_rdata, low_q};
                o_done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_busy  = (state != IDLE);
    assign o_stall = accept || o_busy;
    assign o_sp    = sp;

endmodule

// File: tb/tb_stack_call_sequencer.sv
// Randomized self-checking bench: a word-array stack model predicts every bus cycle and result.
module tb_stack_call_sequencer;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_op_valid;
    logic [2:0]  i_op;
    logic [15:0] i_push_data;
    logic [31:0] i_pc;
    logic [31:0] i_target;
    logic [15:0] mem_rdata;
    logic [15:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic        o_mem_read;
    logic        o_mem_write;
    logic        o_stall;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_pop_data;
    logic        o_pc_load;
    logic [31:0] o_pc_value;
    logic [15:0] o_sp;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned wr_count = 0;

    logic [15:0] bus_mem [65536];
    logic [15:0] ref_mem [65536];
    logic [15:0] m_sp;

    always #5 clk = ~clk;

    stack_call_sequencer #(
        .DATA_W   (16),
        .PC_W     (32),
        .SP_RESET (16'h03FF)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_op_valid  (i_op_valid),
        .i_op        (i_op),
        .i_push_data (i_push_data),
        .i_pc        (i_pc),
        .i_target    (i_target),
        .i_mem_rdata (mem_rdata),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_read  (o_mem_read),
        .o_mem_write (o_mem_write),
        .o_stall     (o_stall),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_pop_data  (o_pop_data),
        .o_pc_load   (o_pc_load),
        .o_pc_value  (o_pc_value),
        .o_sp        (o_sp)
    );

    // Data memory behind the port: one-cycle read latency.
    always @(posedge clk) begin
        if (o_mem_write) begin
            bus_mem[o_mem_addr] <= o_mem_wdata;
            wr_count <= wr_count + 1;
        end
        if (o_mem_read)
            mem_rdata <= bus_mem[o_mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        i_reset    = 1'b0;
        i_op_valid = 1'b0;
        @(negedge clk);
        #1;
        check("rst_busy",   o_busy,      0);
        check("rst_stall",  o_stall,     0);
        check("rst_done",   o_done,      0);
        check("rst_read",   o_mem_read,  0);
        check("rst_write",  o_mem_write, 0);
        check("rst_pcload", o_pc_load,   0);
        check("rst_pcval",  o_pc_value,  0);
        check("rst_addr",   o_mem_addr,  16'h03FF);
        check("rst_wdata",  o_mem_wdata, 0);
        check("rst_pop",    o_pop_data,  0);
        check("rst_sp",     o_sp,        16'h03FF);
        i_reset = 1'b1;
        m_sp    = 16'h03FF;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [15:0] d,
                         input logic [31:0] pc, input logic [31:0] tgt);
        int unsigned ncyc;
        logic        e_wr [3];
        logic        e_rd [3];
        logic        e_ld [3];
        logic [15:0] e_addr [3];
        logic [15:0] e_wd [3];
        logic [15:0] e_sp [3];
        logic [31:0] e_pcv [3];
        logic [15:0] s, s1, s2, sm1, e_pop;
        bit          is_pop;

        s   = m_sp;
        s1  = s + 16'd1;
        s2  = s + 16'd2;
        sm1 = s - 16'd1;
        ncyc   = 0;
        is_pop = 0;
        e_pop  = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            e_wr[k] = 0; e_rd[k] = 0; e_ld[k] = 0;
            e_addr[k] = '0; e_wd[k] = '0; e_sp[k] = '0; e_pcv[k] = '0;
        end
        case (op)
            3'd1: begin
                ncyc = 1;
                e_wr[0] = 1; e_addr[0] = s; e_wd[0] = d; e_sp[0] = s;
                ref_mem[s] = d;
                m_sp = sm1;
            end
            3'd2: begin
                ncyc = 2;
                e_rd[0] = 1; e_addr[0] = s1; e_sp[0] = s; e_sp[1] = s1;
                is_pop = 1; e_pop = ref_mem[s1];
                m_sp = s1;
            end
            3'd3: begin
                ncyc = 2;
                e_wr[0] = 1; e_addr[0] = s;   e_wd[0] = pc[31:16]; e_sp[0] = s;
                e_wr[1] = 1; e_addr[1] = sm1; e_wd[1] = pc[15:0];  e_sp[1] = sm1;
                e_ld[1] = 1; e_pcv[1] = tgt;
                ref_mem[s]   = pc[31:16];
                ref_mem[sm1] = pc[15:0];
                m_sp = s - 16'd2;
            end
            3'd4: begin
                ncyc = 3;
                e_rd[0] = 1; e_addr[0] = s1; e_sp[0] = s;
                e_rd[1] = 1; e_addr[1] = s2; e_sp[1] = s1;
                e_ld[2] = 1; e_pcv[2] = {ref_mem[s2], ref_mem[s1]}; e_sp[2] = s2;
                m_sp = s2;
            end
            default: ncyc = 0;
        endcase

        @(negedge clk);
        i_op_valid  = 1'b1;
        i_op        = op;
        i_push_data = d;
        i_pc        = pc;
        i_target    = tgt;
        #1;
        check("acc_stall", o_stall,     (ncyc > 0));
        check("acc_busy",  o_busy,      0);
        check("acc_read",  o_mem_read,  0);
        check("acc_write", o_mem_write, 0);
        check("acc_done",  o_done,      0);
        check("acc_sp",    o_sp,        s);

        for (int unsigned k = 0; k < ncyc; k++) begin
            @(negedge clk);
            // Requester keeps poking with junk while busy; none of it may be accepted.
            i_op_valid  = (k + 1 < ncyc) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_op        = 3'($urandom_range(0, 7));
            i_push_data = 16'($urandom);
            i_pc        = $urandom;
            i_target    = $urandom;
            #1;
            check("seq_write", o_mem_write, e_wr[k]);
            check("seq_read",  o_mem_read,  e_rd[k]);
            if (e_wr[k] || e_rd[k])
                check("seq_addr", o_mem_addr, e_addr[k]);
            if (e_wr[k])
                check("seq_wdata", o_mem_wdata, e_wd[k]);
            check("seq_done",   o_done,    (k + 1 == ncyc));
            check("seq_pcload", o_pc_load, e_ld[k]);
            if (e_ld[k])
                check("seq_pcval", o_pc_value, e_pcv[k]);
            check("seq_stall", o_stall, 1);
            check("seq_busy",  o_busy,  1);
            check("seq_sp",    o_sp,    e_sp[k]);
            if (is_pop && (k + 1 == ncyc))
                check("pop_data", o_pop_data, e_pop);
        end
    endtask

    initial begin
        i_reset     = 1'b0;
        i_op_valid  = 1'b0;
        i_op        = 3'd0;
        i_push_data = '0;
        i_pc        = '0;
        i_target    = '0;
        m_sp        = 16'h03FF;
        for (int i = 0; i < 65536; i++) begin
            bus_mem[i] = '0;
            ref_mem[i] = '0;
        end

        apply_reset();
        do_op(3'd1, 16'hBEEF, '0, '0);

        apply_reset();
        do_op(3'd1, 16'h1234, '0, '0);
        do_op(3'd2, 16'h0000, '0, '0);

        apply_reset();
        do_op(3'd3, 16'h0000, 32'h0001_0020, 32'h0000_0400);
        do_op(3'd4, 16'h0000, '0, '0);
        do_op(3'd5, 16'hAAAA, '0, '0);
        do_op(3'd0, 16'h5555, '0, '0);

        // Reset while the CALL low word is being written.
        apply_reset();
        @(negedge clk);
        i_op_valid = 1'b1; i_op = 3'd3; i_pc = 32'h0001_0020; i_target = 32'h0000_0400;
        @(negedge clk);
        i_op_valid = 1'b0;
        #1;
        check("mid_wra_addr", o_mem_addr, 16'h03FF);
        @(negedge clk);
        #1;
        check("mid_wrb_addr", o_mem_addr, 16'h03FE);
        i_reset = 1'b0;
        @(negedge clk);
        #1;
        i_reset = 1'b1;
        check("mid_busy",   o_busy,      0);
        check("mid_write",  o_mem_write, 0);
        check("mid_read",   o_mem_read,  0);
        check("mid_pcload", o_pc_load,   0);
        check("mid_sp",     o_sp,        16'h03FF);
        ref_mem[16'h03FF] = 16'h0001;
        ref_mem[16'h03FE] = 16'h0020;
        m_sp = 16'h03FF;
        begin
            int unsigned wr_before;
            wr_before = wr_count;
            repeat (3) @(negedge clk);
            check("mid_no_write", wr_count - wr_before, 0);
        end

        apply_reset();
        repeat (1024) do_op(3'd1, 16'($urandom), '0, '0);
        @(negedge clk);
        #1;
        check("wrap_sp", o_sp, 16'hFFFF);
        do_op(3'd1, 16'hC0DE, '0, '0);
        do_op(3'd2, 16'h0000, '0, '0);

        repeat (400)
            do_op(3'($urandom_range(0, 7)), 16'($urandom), $urandom, $urandom);

        @(negedge clk);
        i_op_valid = 1'b0;
        #1;
        check("final_sp", o_sp, m_sp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
